// File: rtl/x4_approx_sub_pkg.sv
// Shared types and helpers for the nibble-serial approximate subtractor.
// Cell equations, slice count and per-nibble approximation mask live here.
package x4_approx_sub_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  function automatic int unsigned nib_count(input int unsigned width);
    return width / 4;
  endfunction

  // Bit j set iff absolute bit 4*nib_idx+j falls below the approximate region boundary.
  function automatic logic [3:0] approx_mask(input int unsigned nib_idx,
                                             input int unsigned approx_bits);
    logic [3:0] m;
    for (int unsigned j = 0; j < 4; j++) begin
      m[j] = ((4 * nib_idx + j) < approx_bits);
    end
    return m;
  endfunction

  // Returns {borrow_out, difference}.
  function automatic logic [1:0] cell_exact(input logic a, input logic b, input logic bi);
    return {(~a & b) | (~(a ^ b) & bi), a ^ b ^ bi};
  endfunction

  function automatic logic [1:0] cell_approx(input logic a, input logic b);
    return {~a & b, a ^ b};
  endfunction

endpackage

// File: rtl/x4_approx_sub.sv
// Combinational 4-bit subtract slice; each bit picks the approximate or exact cell
// from approx_mask, and the borrow ripples LSB to MSB.
module x4_approx_sub
  import x4_approx_sub_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       bin,
  input  logic [3:0] approx_mask,
  output logic [3:0] d,
  output logic       bout
);

  logic       br;
  logic [1:0] r;

  always_comb begin
    br = bin;
    r  = '0;
    d  = '0;
    for (int j = 0; j < 4; j++) begin
      r    = approx_mask[j] ? cell_approx(a[j], b[j]) : cell_exact(a[j], b[j], br);
      d[j] = r[0];
      br   = r[1];
    end
    bout = br;
  end

endmodule

// File: rtl/x4_approx_sub_seq.sv
// Nibble-serial approximate subtractor: diff = a - b - bin, one 4-bit slice per clock, LS first.
// Define APPROX_SUB_ERR_EN to add a parallel exact chain and the |exact - approx| err output.
module x4_approx_sub_seq
  import x4_approx_sub_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned APPROX_BITS = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef APPROX_SUB_ERR_EN
  ,
  output logic [WIDTH-1:0] err
`endif
);

  localparam int unsigned NIB  = nib_count(WIDTH);
  localparam int unsigned CntW = (NIB > 1) ? $clog2(NIB) : 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic             borrow_q, borrow_d, bout_q, bout_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             last_nib;
  logic [3:0]       mask, slice_d;
  logic             slice_bout;
  logic [WIDTH+3:0] diff_shift;

  assign last_nib   = (cnt_q == CntW'(NIB - 1));
  assign mask       = approx_mask(32'(cnt_q), APPROX_BITS);
  // New nibble enters at the MSB side; after NIB shifts the LS nibble sits at bit 0.
  assign diff_shift = {slice_d, diff_q};

  x4_approx_sub u_slice (
    .a           (a_q[3:0]),
    .b           (b_q[3:0]),
    .bin         (borrow_q),
    .approx_mask (mask),
    .d           (slice_d),
    .bout        (slice_bout)
  );

`ifdef APPROX_SUB_ERR_EN
  logic [WIDTH-1:0] ex_diff_q, ex_diff_d, err_q, err_d;
  logic             ex_borrow_q, ex_borrow_d;
  logic [3:0]       ex_slice_d;
  logic             ex_slice_bout;
  logic [WIDTH+3:0] ex_shift;
  logic [WIDTH-1:0] ex_next, ap_next;

  x4_approx_sub u_slice_exact (
    .a           (a_q[3:0]),
    .b           (b_q[3:0]),
    .bin         (ex_borrow_q),
    .approx_mask (4'b0000),
    .d           (ex_slice_d),
    .bout        (ex_slice_bout)
  );

  assign ex_shift = {ex_slice_d, ex_diff_q};
  assign ex_next  = ex_shift[WIDTH+3:4];
  assign ap_next  = diff_shift[WIDTH+3:4];
  assign err      = err_q;
`endif

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    cnt_d    = cnt_q;
`ifdef APPROX_SUB_ERR_EN
    ex_diff_d   = ex_diff_q;
    ex_borrow_d = ex_borrow_q;
    err_d       = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          borrow_d = bin;
          cnt_d    = '0;
          state_d  = StRun;
`ifdef APPROX_SUB_ERR_EN
          ex_borrow_d = bin;
`endif
        end
      end
      StRun: begin
        a_d      = a_q >> 4;
        b_d      = b_q >> 4;
        diff_d   = diff_shift[WIDTH+3:4];
        borrow_d = slice_bout;
        cnt_d    = cnt_q + CntW'(1);
`ifdef APPROX_SUB_ERR_EN
        ex_diff_d   = ex_next;
        ex_borrow_d = ex_slice_bout;
`endif
        if (last_nib) begin
          bout_d  = slice_bout;
          state_d = StDone;
`ifdef APPROX_SUB_ERR_EN
          err_d = (ex_next >= ap_next) ? (ex_next - ap_next) : (ap_next - ex_next);
`endif
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      cnt_q    <= '0;
`ifdef APPROX_SUB_ERR_EN
      ex_diff_q   <= '0;
      ex_borrow_q <= 1'b0;
      err_q       <= '0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      cnt_q    <= cnt_d;
`ifdef APPROX_SUB_ERR_EN
      ex_diff_q   <= ex_diff_d;
      ex_borrow_q <= ex_borrow_d;
      err_q       <= err_d;
`endif
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign diff      = diff_q;
  assign bout      = bout_q;

endmodule
